// File: rtl/tcb_uart_bridge_if.sv
// TCB bus bundle used by tcb_uart_bridge.
// Parameter:
//   DLY     - subordinate response latency in cycles (0 or 1)
// Signals:
//   vld/rdy - request handshake
//   wen     - write enable (1 = write, 0 = read)
//   adr     - byte address, 32 bit
//   wdt/ben - write data and byte enables
//   rdt/err - response data and error flag, valid DLY cycles after vld&rdy
// Modports: master (bus manager side), slave (subordinate side).
interface tcb_uart_bridge_if #(
    parameter int unsigned DLY = 0
) ();
    logic        vld;
    logic        rdy;
    logic        wen;
    logic [31:0] adr;
    logic [31:0] wdt;
    logic [3:0]  ben;
    logic [31:0] rdt;
    logic        err;

    modport master (
        output vld, wen, adr, wdt, ben,
        input  rdy, rdt, err
    );

    modport slave (
        input  vld, wen, adr, wdt, ben,
        output rdy, rdt, err
    );
endinterface

// File: rtl/tcb_uart_bridge.sv
// UART-to-TCB debug bridge. Receives command frames on uart_rxd, performs one
// 32-bit TCB access as bus manager and sends the response on uart_txd.
//   Write frame: 01 ADR[4] WDT[4]  -> response: STATUS
//   Read frame:  02 ADR[4]         -> response: RDT[4] STATUS
//   Multi-byte fields are little-endian; STATUS is 00 (ok) or 01 (tcb.err).
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset
//   uart_rxd - serial input, 8N1, LSB first, idle high
//   uart_txd - serial output, 8N1, LSB first, idle high
//   tcb      - TCB manager port; response latency taken from tcb.DLY (0 or 1)
//   busy     - high from command byte acceptance until the last stop bit ends
module tcb_uart_bridge #(
    parameter int unsigned BDR = 4,
    parameter int unsigned SMP = BDR / 2,
    parameter int unsigned TMO = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic              uart_txd,
    tcb_uart_bridge_if.master tcb,
    output logic              busy
);
    localparam int unsigned     Dly     = tcb.DLY;
    localparam int unsigned     CntW    = $clog2(BDR + SMP + 1);
    localparam int unsigned     TmoW    = $clog2(TMO + 1);
    localparam logic [CntW-1:0] BitLast = CntW'(BDR - 1);
    localparam logic [CntW-1:0] SmpLast = CntW'(SMP - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO - 1);
    localparam logic [7:0]      CmdWr   = 8'h01;
    localparam logic [7:0]      CmdRd   = 8'h02;

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shf_q, rx_shf_d;
    logic            rx_vld_q, rx_vld_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shf_d   = rx_shf_q;
        rx_vld_d   = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = SmpLast;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    // A start bit that reads high again was only a glitch.
                    rx_state_d = rxd_sync_q ? RxIdle : RxData;
                    rx_cnt_d   = BitLast;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_shf_d = {rxd_sync_q, rx_shf_q[7:1]};
                    rx_cnt_d = BitLast;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    // Stop bit low is a framing error: byte dropped.
                    rx_state_d = RxIdle;
                    rx_vld_d   = rxd_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------------------------------------------- frame / bus / TX
    typedef enum logic [2:0] {StIdle, StAdr, StDat, StReq, StRsp, StTx} state_e;

    state_e          st_q, st_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            wen_q, wen_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     wdt_q, wdt_d;
    logic [3:0]      ben_q, ben_d;
    logic            vld_q, vld_d;
    logic [31:0]     rsp_q, rsp_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_left_q, tx_left_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            cap;
    logic [39:0]     rsp_full;

    // Response bytes in transmit order, first byte in bits [7:0].
    assign rsp_full = wen_q ? {32'h0, 7'h0, tcb.err} : {7'h0, tcb.err, tcb.rdt};

    always_comb begin
        st_d       = st_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        wen_d      = wen_q;
        adr_d      = adr_q;
        wdt_d      = wdt_q;
        ben_d      = ben_q;
        vld_d      = vld_q;
        rsp_d      = rsp_q;
        tx_byte_d  = tx_byte_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_left_d  = tx_left_q;
        txd_d      = txd_q;
        cap        = 1'b0;
        case (st_q)
            StIdle: begin
                tmo_d = '0;
                if (rx_vld_q && (rx_shf_q == CmdWr || rx_shf_q == CmdRd)) begin
                    st_d       = StAdr;
                    wen_d      = (rx_shf_q == CmdWr);
                    byte_cnt_d = '0;
                end
            end
            StAdr, StDat: begin
                if (rx_vld_q) begin
                    tmo_d      = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (st_q == StAdr) begin
                        adr_d = {rx_shf_q, adr_q[31:8]};
                    end else begin
                        wdt_d = {rx_shf_q, wdt_q[31:8]};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        if (st_q == StAdr && wen_q) begin
                            st_d = StDat;
                        end else begin
                            st_d  = StReq;
                            vld_d = 1'b1;
                            ben_d = 4'hF;
                        end
                    end
                end else if (tmo_q == TmoLast) begin
                    st_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StReq: begin
                if (tcb.rdy) begin
                    vld_d = 1'b0;
                    if (Dly == 0) begin
                        cap = 1'b1;
                    end else begin
                        st_d = StRsp;
                    end
                end
            end
            StRsp: cap = 1'b1;
            StTx: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BitLast;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_left_q != 3'd0) begin
                            tx_byte_d = rsp_q[7:0];
                            rsp_d     = {8'h0, rsp_q[31:8]};
                            tx_left_d = tx_left_q - 3'd1;
                            tx_bit_d  = '0;
                            txd_d     = 1'b0;
                        end else begin
                            st_d  = StIdle;
                            txd_d = 1'b1;
                        end
                    end else begin
                        // Bit slots: 0 start, 1..8 data, 9 stop.
                        tx_bit_d = tx_bit_q + 4'd1;
                        txd_d    = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_q[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CntW'(1);
                end
            end
            default: st_d = StIdle;
        endcase

        // Capture the response and start the first start bit next cycle.
        if (cap) begin
            st_d      = StTx;
            tx_byte_d = rsp_full[7:0];
            rsp_d     = rsp_full[39:8];
            tx_left_d = wen_q ? 3'd0 : 3'd4;
            tx_bit_d  = '0;
            tx_cnt_d  = BitLast;
            txd_d     = 1'b0;
        end

        busy_d = (st_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shf_q   <= '0;
            rx_vld_q   <= 1'b0;
            st_q       <= StIdle;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            wdt_q      <= '0;
            ben_q      <= '0;
            vld_q      <= 1'b0;
            rsp_q      <= '0;
            tx_byte_q  <= '0;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_left_q  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shf_q   <= rx_shf_d;
            rx_vld_q   <= rx_vld_d;
            st_q       <= st_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            wen_q      <= wen_d;
            adr_q      <= adr_d;
            wdt_q      <= wdt_d;
            ben_q      <= ben_d;
            vld_q      <= vld_d;
            rsp_q      <= rsp_d;
            tx_byte_q  <= tx_byte_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_left_q  <= tx_left_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign tcb.vld  = vld_q;
    assign tcb.wen  = wen_q;
    assign tcb.adr  = adr_q;
    assign tcb.wdt  = wdt_q;
    assign tcb.ben  = ben_q;
endmodule

// File: tb/tb_tcb_uart_bridge.sv
// Bench for tcb_uart_bridge: two bridges (DLY=0 and DLY=1) share one RX line
// and subordinate behaviour; each has its own bus monitor and UART decoder
// checked against a frame-level reference model.
module tb_tcb_uart_bridge;
    localparam int unsigned BDR = 4;
    localparam int unsigned TMO = 200;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Subordinate behaviour and expected results, written only by the main process.
    int          sub_wait = 0;
    logic [31:0] sub_rdt  = '0;
    logic        sub_err  = 1'b0;
    int          frame_id = 0;
    logic        chk_en   = 1'b0;
    logic        exp_txn;
    logic        exp_wen;
    logic [31:0] exp_adr, exp_wdt;
    byte_t       exp_tx [5];
    int          exp_tx_n = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tcb_uart_bridge_if #(.DLY(g)) tcb_if ();
        logic txd, busy;
        int   wcnt = 0;
        logic hs_q = 1'b0;
        logic cap_now;
        int   bus_seen = -1, bus_n = 0;
        int   tx_seen = -1, tx_pos = 0;

        tcb_uart_bridge #(.BDR(BDR), .SMP(BDR / 2), .TMO(TMO)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .uart_rxd(rxd),
            .uart_txd(txd),
            .tcb     (tcb_if),
            .busy    (busy)
        );

        // Subordinate: rdy after sub_wait stalled cycles; response valid only
        // in the capture cycle, inverted garbage otherwise.
        assign tcb_if.rdy = tcb_if.vld && (wcnt >= sub_wait);
        assign cap_now    = (g == 0) ? (tcb_if.vld && tcb_if.rdy) : hs_q;
        assign tcb_if.rdt = cap_now ? sub_rdt : ~sub_rdt;
        assign tcb_if.err = cap_now ? sub_err : ~sub_err;
        always @(posedge clk) begin
            wcnt <= (tcb_if.vld && !tcb_if.rdy) ? wcnt + 1 : 0;
            hs_q <= tcb_if.vld && tcb_if.rdy;
        end

        // Bus monitor.
        initial begin
            int run;
            run = 0;
            forever begin
                @(negedge clk);
                if (tcb_if.vld === 1'b1) begin
                    run++;
                    if (tcb_if.rdy === 1'b1) begin
                        if (bus_seen != frame_id) begin
                            bus_seen = frame_id;
                            bus_n    = 0;
                        end
                        bus_n++;
                        if (chk_en) begin
                            check($sformatf("i%0d wen", g), tcb_if.wen, exp_wen);
                            check($sformatf("i%0d adr", g), tcb_if.adr, exp_adr);
                            check($sformatf("i%0d ben", g), tcb_if.ben, 4'hF);
                            if (exp_wen) check($sformatf("i%0d wdt", g), tcb_if.wdt, exp_wdt);
                            check($sformatf("i%0d vld cycles", g), run, sub_wait + 1);
                            for (int c = 1; c <= g + 1; c++) begin
                                @(negedge clk);
                                check($sformatf("i%0d tx start c%0d", g, c), txd,
                                      (c == g + 1) ? 1'b0 : 1'b1);
                            end
                        end
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end
        end

        // UART TX decoder.
        initial begin
            int    st, last_st;
            byte_t b;
            logic  sb, stp;
            last_st = 0;
            forever begin
                @(negedge txd);
                @(negedge clk);
                st = cyc;
                repeat (BDR / 2 - 1) @(negedge clk);
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (BDR) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BDR) @(negedge clk);
                stp = txd;
                if (tx_seen != frame_id) begin
                    tx_seen = frame_id;
                    tx_pos  = 0;
                end
                if (chk_en) begin
                    check($sformatf("i%0d tx start bit", g), sb, 1'b0);
                    check($sformatf("i%0d tx stop bit", g), stp, 1'b1);
                    if (tx_pos < exp_tx_n)
                        check($sformatf("i%0d tx byte %0d", g, tx_pos), b, exp_tx[tx_pos]);
                    if (tx_pos > 0)
                        check($sformatf("i%0d tx byte spacing", g), st - last_st, 10 * BDR);
                    if (tx_pos == exp_tx_n - 1) begin
                        repeat (BDR - BDR / 2) @(negedge clk);
                        check($sformatf("i%0d busy before stop end", g), busy, 1'b1);
                        @(negedge clk);
                        check($sformatf("i%0d busy after stop end", g), busy, 1'b0);
                    end
                end
                last_st = st;
                tx_pos++;
            end
        end
    end

    // Reference model: decode a whole frame into the expected bus access and reply.
    task automatic model(input byte_t f[$]);
        logic [7:0] status;
        status   = {7'h0, sub_err};
        exp_txn  = 1'b0;
        exp_tx_n = 0;
        if (f.size() == 9 && f[0] == 8'h01) begin
            exp_txn   = 1'b1;
            exp_wen   = 1'b1;
            exp_adr   = {f[4], f[3], f[2], f[1]};
            exp_wdt   = {f[8], f[7], f[6], f[5]};
            exp_tx[0] = status;
            exp_tx_n  = 1;
        end else if (f.size() == 5 && f[0] == 8'h02) begin
            exp_txn = 1'b1;
            exp_wen = 1'b0;
            exp_adr = {f[4], f[3], f[2], f[1]};
            for (int i = 0; i < 4; i++) exp_tx[i] = sub_rdt[8*i +: 8];
            exp_tx[4] = status;
            exp_tx_n  = 5;
        end
    endtask

    task automatic bit_out(input logic v);
        rxd = v;
        repeat (BDR) @(negedge clk);
    endtask

    task automatic send_byte(input byte_t b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input byte_t f[$]);
        foreach (f[i]) begin
            send_byte(f[i], 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((g_dut[0].busy !== 1'b0 || g_dut[1].busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("both bridges idle", {g_dut[0].busy, g_dut[1].busy}, 2'b00);
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input byte_t f[$], input int wt, input logic [31:0] rdt,
                             input logic err);
        frame_id++;
        chk_en   = 1'b1;
        sub_wait = wt;
        sub_rdt  = rdt;
        sub_err  = err;
        model(f);
        send_frame(f);
        wait_idle();
        check("i0 bus count", (g_dut[0].bus_seen == frame_id) ? g_dut[0].bus_n : 0, exp_txn);
        check("i1 bus count", (g_dut[1].bus_seen == frame_id) ? g_dut[1].bus_n : 0, exp_txn);
        check("i0 tx count", (g_dut[0].tx_seen == frame_id) ? g_dut[0].tx_pos : 0, exp_tx_n);
        check("i1 tx count", (g_dut[1].tx_seen == frame_id) ? g_dut[1].tx_pos : 0, exp_tx_n);
        check("txd idle", {g_dut[0].txd, g_dut[1].txd}, 2'b11);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " vld"}, {g_dut[0].tcb_if.vld, g_dut[1].tcb_if.vld}, 2'b00);
        check({tag, " txd"}, {g_dut[0].txd, g_dut[1].txd}, 2'b11);
        check({tag, " busy"}, {g_dut[0].busy, g_dut[1].busy}, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t       f[$];
        logic [31:0] a, d;
        int          n;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("i0 reset ctl", {g_dut[0].txd, g_dut[0].busy, g_dut[0].tcb_if.vld,
                               g_dut[0].tcb_if.wen, g_dut[0].tcb_if.ben}, 8'h80);
        check("i1 reset ctl", {g_dut[1].txd, g_dut[1].busy, g_dut[1].tcb_if.vld,
                               g_dut[1].tcb_if.wen, g_dut[1].tcb_if.ben}, 8'h80);
        check("i0 reset adr", g_dut[0].tcb_if.adr, 32'h0);
        check("i1 reset wdt", g_dut[1].tcb_if.wdt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Directed frames.
        run_frame('{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00}, 0, 32'h0, 1'b0);
        run_frame('{8'h02, 8'h20, 8'h00, 8'h00, 8'h00}, 0, 32'hDEADBEEF, 1'b0);
        run_frame('{8'h02, 8'h21, 8'h43, 8'h65, 8'h87}, 7, 32'h0BADF00D, 1'b1);

        // Invalid command, line glitch, framing error: nothing happens.
        frame_id++;
        chk_en   = 1'b1;
        exp_tx_n = 0;
        send_byte(8'h7A, 1'b1);
        repeat (10) @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h01, 1'b0);
        repeat (20) @(negedge clk);
        wait_idle();
        check("invalid i0 bus", (g_dut[0].bus_seen == frame_id) ? g_dut[0].bus_n : 0, 0);
        check("invalid i1 tx", (g_dut[1].tx_seen == frame_id) ? g_dut[1].tx_pos : 0, 0);
        check("invalid txd", {g_dut[0].txd, g_dut[1].txd}, 2'b11);

        // Partial frame times out, then a full read works.
        run_frame('{8'h01, 8'h08, 8'h00}, 0, 32'h0, 1'b0);
        run_frame('{8'h02, 8'h04, 8'h00, 8'h00, 8'h10}, 1, 32'h12345678, 1'b0);

        // Reset while stuck in REQ, then a normal write.
        frame_id++;
        chk_en   = 1'b0;
        sub_wait = 100000;
        send_frame('{8'h02, 8'h40, 8'h00, 8'h00, 8'h00});
        n = 0;
        while (g_dut[0].tcb_if.vld !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("vld seen before reset", g_dut[0].tcb_if.vld, 1'b1);
        repeat (5) @(negedge clk);
        reset_pulse("reset in req");
        run_frame('{8'h01, 8'hFC, 8'hFF, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hCC, 8'h33}, 2, 32'h0,
                  1'b0);

        // Reset while transmitting, then a normal read.
        frame_id++;
        chk_en   = 1'b0;
        sub_wait = 0;
        sub_rdt  = 32'hFFFFFFFF;
        send_frame('{8'h02, 8'h00, 8'h01, 8'h00, 8'h00});
        n = 0;
        while (g_dut[0].txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("txd active before reset", g_dut[0].txd, 1'b0);
        repeat (10) @(negedge clk);
        reset_pulse("reset in tx");
        run_frame('{8'h02, 8'h10, 8'h00, 8'h00, 8'h00}, 0, 32'hA5C3_0F96, 1'b1);

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            d = $urandom;
            f = {};
            if ($urandom_range(0, 1) == 1) begin
                f.push_back(8'h01);
                for (int i = 0; i < 4; i++) f.push_back(a[8*i +: 8]);
                for (int i = 0; i < 4; i++) f.push_back(d[8*i +: 8]);
            end else begin
                f.push_back(8'h02);
                for (int i = 0; i < 4; i++) f.push_back(a[8*i +: 8]);
            end
            run_frame(f, $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tcb_uart_bridge.md
# tcb_uart_bridge

UART-to-TCB debug bridge: receives binary command frames on a UART RX line, issues the corresponding 32-bit TCB read or write as a bus manager, and returns the response over UART TX. It is the initiator-side counterpart of the UART peripheral: a host PC, or a testbench UART model, gains register access to any TCB subordinate, including the UART peripheral itself. The bridge sits at the top of a TCB interconnect as one manager port.

## Interface

Parameters:
- `BDR`, default 4: clock cycles per UART bit, for both TX and RX; minimum 4.
- `SMP`, default `BDR/2`: cycles from the start-bit falling edge to the start-bit sample point.
- `TMO`, default 1024: inter-byte timeout in cycles while a frame is partially received.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `uart_rxd`, input, 1: serial receive, 8N1, LSB first, idle high.
- `uart_txd`, output, 1: serial transmit, 8N1, LSB first, idle high.
- `tcb`, interface (manager modport), PHY ABW=32 DBW=32: TCB manager port (`vld`, `rdy`, `wen`, `adr`, `wdt`, `ben`, `rdt`, `err`); response latency is `tcb.PHY.DLY`, and only DLY 0 and 1 are supported.
- `busy`, output, 1: high from first command-byte acceptance until the last TX stop bit ends.

## Operation

- **RX path**
  - 2-flop synchronizer on `uart_rxd`.
  - A falling edge in RX idle starts a byte. The start bit is sampled `SMP` cycles later; if it reads high, the byte is discarded as a glitch.
  - Data bits are sampled every `BDR` cycles after the start sample; the stop bit is sampled after data bit 7.
  - A stop bit reading 0 is a framing error: the byte is dropped and the FSM returns to IDLE.
- **Frame format** (all multi-byte fields little-endian):
  - Write: `0x01`, ADR[4], WDT[4].
  - Read: `0x02`, ADR[4].
  - Any other command byte in IDLE is silently dropped.
- **FSM states**
  - IDLE: wait for a command byte.
  - ADR: collect 4 bytes.
  - DAT: collect 4 bytes (write only).
  - REQ: `tcb.vld`=1 with `wen`, `adr`, `wdt` and `ben`=4'hF held stable until `vld&rdy`.
  - RSP: capture `rdt`/`err` `DLY` cycles after the handshake.
  - TX: shift out the response bytes.
  - Return to IDLE.
- **Responses**
  - Write: 1 status byte.
  - Read: RDT[4] little-endian, then 1 status byte.
  - Status byte: `0x00` OK, `0x01` if `tcb.err` was set.
- **Timeout:** in ADR or DAT, `TMO` cycles with no completed byte aborts the frame to IDLE with no TCB transfer and no TX.
- Bytes completed while in REQ, RSP or TX are dropped and are not queued.
- `tcb.adr` is passed through unmodified; it is not word-aligned by the bridge.

## Timing

- **Reset values:** `uart_txd`=1, `tcb.vld`=0, `tcb.wen`=0, `tcb.adr`=0, `tcb.wdt`=0, `tcb.ben`=0, `busy`=0. The FSM enters IDLE and the RX/TX counters clear.
- **RX byte-valid strobe:** 1 cycle, asserted the cycle after the stop-bit sample.
- **Final frame byte to request:** `tcb.vld` asserts the cycle after the strobe of the final frame byte.
- **Handshake:**
  - `vld` stays high until the cycle where `rdy`=1, then deasserts the next cycle.
  - There is never more than one outstanding transfer.
  - `rdy` stuck low holds REQ indefinitely; the RX timeout does not apply in REQ.
- **Response capture:**
  - DLY=0: `rdt`/`err` are captured in the handshake cycle.
  - DLY=1: captured one cycle later.
- **TX:**
  - The start bit begins the cycle after capture.
  - Each bit lasts `BDR` cycles, so each byte takes 10×`BDR` cycles.
  - Bytes are sent back-to-back with no idle bits between them.
- **`busy`** drops in the cycle after the final stop bit period.
- **Asynchronous reset mid-transfer:** `vld` drops immediately; any partial frame or TX is abandoned, and `uart_txd` goes high.

## Test plan

- **Write:** RX `01 08 00 00 00 03 00 00 00` with subordinate `rdy`=1, DLY=0 → one TCB write with `adr`=0x08, `wdt`=0x00000003, `ben`=0xF; TX `00`.
- **Read:** RX `02 20 00 00 00`, subordinate returns `rdt`=0xDEADBEEF → TX `EF BE AD DE 00`; repeat with DLY=1 and expect the same bytes.
- **Error and backpressure:** read with `err`=1 and `rdy` held low for 7 cycles → `vld` high for exactly 8 cycles; status byte `01`.
- **Invalid input:** RX `7A`, then a 1-cycle low glitch on `rxd`, then a byte with stop bit 0 → no TCB transfer, `uart_txd` stays 1, `busy` back to 0.
- **Timeout:** RX `01 08 00` then silence for `TMO`+10 cycles, then a full valid read frame → no write issued; the read completes normally.
- **Reset:** assert `rst` during REQ and during TX → `vld`=0 and `uart_txd`=1 immediately; after release, the next frame executes correctly.
